// File: rtl/turtle_fetch_pkg.sv
// Shared definitions for the turtle front end: fetch FSM encoding and the
// default widths used by the fetch unit, control unit and top level.
package turtle_fetch_pkg;

  localparam int DEF_INST_W   = 5;
  localparam int DEF_PC_W     = 8;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, inst} entries: registered storage, combinational
// head read, flush clears everything in one cycle and beats a push.
module fetch_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [W-1:0]     o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !i_flush && (r_count != CNT_W'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues one outstanding imem request at a time,
// buffers results in fetch_fifo and handles redirect/flush.
module instruction_fetch_unit
  import turtle_fetch_pkg::*;
#(
  parameter int              INST_W   = DEF_INST_W,
  parameter int              PC_W     = DEF_PC_W,
  parameter int              DEPTH    = DEF_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int E_W   = PC_W + INST_W;

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [PC_W-1:0]  r_fetch_pc;
  logic [PC_W-1:0]  w_fetch_pc_next;
  logic [PC_W-1:0]  r_drop_addr;
  logic [PC_W-1:0]  w_drop_addr_next;
  logic [CNT_W-1:0] w_count;
  logic [E_W-1:0]   w_head;
  logic             w_not_full;
  logic             w_push;
  logic             w_pop;
  logic             w_req;
  logic [PC_W-1:0]  w_addr;

  assign w_not_full = (w_count < CNT_W'(DEPTH));
  assign inst_valid = (w_count != '0);
  assign w_pop      = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= RESET_PC;
    end else begin
      r_state     <= w_state_next;
      r_fetch_pc  <= w_fetch_pc_next;
      r_drop_addr <= w_drop_addr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_fetch_pc_next  = r_fetch_pc;
    w_drop_addr_next = r_drop_addr;
    case (r_state)
      ST_IDLE: begin
        if (redirect)        w_fetch_pc_next = redirect_pc;
        else if (w_not_full) w_state_next    = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect) begin
          w_fetch_pc_next = redirect_pc;
          if (imem_ack) begin
            w_state_next = ST_IDLE;
          end else begin
            // Request still in flight: keep its address alive until it acks.
            w_state_next     = ST_DROP;
            w_drop_addr_next = r_fetch_pc;
          end
        end else if (imem_ack) begin
          w_fetch_pc_next = r_fetch_pc + PC_W'(1);
          w_state_next    = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (redirect) w_fetch_pc_next = redirect_pc;
        if (imem_ack) w_state_next    = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req  = 1'b0;
    w_addr = r_fetch_pc;
    w_push = 1'b0;
    case (r_state)
      ST_IDLE:  w_req = !redirect && w_not_full;
      ST_FETCH: begin
        w_req  = 1'b1;
        w_push = imem_ack && !redirect;
      end
      ST_DROP: begin
        w_req  = 1'b1;
        w_addr = r_drop_addr;
      end
      default: w_req = 1'b0;
    endcase
  end

  // A request raised while reset is held would be abandoned anyway.
  assign imem_req  = w_req && !reset;
  assign imem_addr = w_addr;

  fetch_fifo #(
    .W     (E_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({r_fetch_pc, imem_data}),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign inst    = inst_valid ? w_head[INST_W-1:0]   : '0;
  assign inst_pc = inst_valid ? w_head[E_W-1:INST_W] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle vector table plus scoreboarded
// multi-cycle sequences against a configurable-latency memory model.
module tb_instruction_fetch_unit;

  logic       clk;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [4:0] imem_data;
  logic [4:0] inst;
  logic [7:0] inst_pc;
  logic       inst_valid;
  logic       inst_ready;
  logic       redirect;
  logic [7:0] redirect_pc;

  int n_tests     = 0;
  int n_fail      = 0;
  int sb_consumed = 0;
  int mem_age     = 0;
  int mem_delay   = 0;
  logic [12:0] sb_q[$];

  typedef struct {
    logic       ready;
    logic       redir;
    logic [7:0] rpc;
    logic       req;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] pc;
    logic [4:0] inst;
  } vec_t;

  vec_t vecs[15];

  instruction_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks after mem_delay wait cycles in FETCH, data = addr[4:0].
  assign imem_ack  = imem_req && (mem_age >= mem_delay + 1);
  assign imem_data = imem_ack ? imem_addr[4:0] : 5'h00;

  always @(posedge clk) begin
    if (reset || !imem_req || imem_ack) mem_age <= 0;
    else                                mem_age <= mem_age + 1;
  end

  function automatic vec_t mk(input logic rdy, input logic rd, input logic [7:0] rpc,
                              input logic rq, input logic [7:0] ad, input logic vl,
                              input logic [7:0] pc, input logic [4:0] in);
    vec_t v;
    v.ready = rdy; v.redir = rd; v.rpc = rpc;
    v.req = rq; v.addr = ad; v.valid = vl; v.pc = pc; v.inst = in;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    logic [12:0] exp;
    if (!reset && inst_valid && inst_ready) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected act_pc=%0h act_inst=%0h exp=none", inst_pc, inst);
      end else begin
        exp = sb_q.pop_front();
        if ({inst_pc, inst} !== exp) begin
          n_fail++;
          $display("FAIL sb_data act_pc=%0h act_inst=%0h exp_pc=%0h exp_inst=%0h",
                   inst_pc, inst, exp[12:5], exp[4:0]);
        end else begin
          $display("[TB] pop pc=%0h inst=%0h ok", inst_pc, inst);
        end
      end
      sb_consumed++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_check();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      nxt();
    end
  endtask

  task automatic push_seq(input logic [7:0] start, input int n);
    logic [7:0] pc;
    for (int k = 0; k < n; k++) begin
      pc = start + 8'(k);
      sb_q.push_back({pc, pc[4:0]});
    end
  endtask

  task automatic wait_consumed(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (sb_consumed < n && k < budget) begin
      tick();
      nxt();
      k++;
    end
    chk(name, sb_consumed, n);
  endtask

  // Leaves the bench at posedge+1 of the first cycle out of reset.
  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    inst_ready  = 1'b0;
    sb_q.delete();
    sb_consumed = 0;
    nxt();
    nxt();
    tick();
    chk("reset_state", {imem_req, imem_addr, inst_valid, inst_pc, inst},
        {1'b0, 8'h00, 1'b0, 8'h00, 5'h00});
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait stream, then redirect 0xFE coinciding with an ack, then wrap.
    vecs[0]  = mk(1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 5'h00);
    vecs[1]  = mk(1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 5'h00);
    vecs[2]  = mk(1, 0, 8'h00, 1, 8'h01, 1, 8'h00, 5'h00);
    vecs[3]  = mk(1, 0, 8'h00, 1, 8'h01, 0, 8'h00, 5'h00);
    vecs[4]  = mk(1, 0, 8'h00, 1, 8'h02, 1, 8'h01, 5'h01);
    vecs[5]  = mk(1, 1, 8'hFE, 1, 8'h02, 0, 8'h00, 5'h00);
    vecs[6]  = mk(1, 0, 8'h00, 1, 8'hFE, 0, 8'h00, 5'h00);
    vecs[7]  = mk(1, 0, 8'h00, 1, 8'hFE, 0, 8'h00, 5'h00);
    vecs[8]  = mk(1, 0, 8'h00, 1, 8'hFF, 1, 8'hFE, 5'h1E);
    vecs[9]  = mk(1, 0, 8'h00, 1, 8'hFF, 0, 8'h00, 5'h00);
    vecs[10] = mk(1, 0, 8'h00, 1, 8'h00, 1, 8'hFF, 5'h1F);
    vecs[11] = mk(1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 5'h00);
    vecs[12] = mk(1, 0, 8'h00, 1, 8'h01, 1, 8'h00, 5'h00);
    vecs[13] = mk(1, 0, 8'h00, 1, 8'h01, 0, 8'h00, 5'h00);
    vecs[14] = mk(1, 0, 8'h00, 1, 8'h02, 1, 8'h01, 5'h01);

    reset = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

    // Table: startup stream, redirect with ack, PC wrap.
    mem_delay = 0;
    do_reset();
    push_seq(8'h00, 2);
    push_seq(8'hFE, 4);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) nxt();
      inst_ready  = vecs[i].ready;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      tick();
      chk($sformatf("vec%0d", i), {imem_req, imem_addr, inst_valid, inst_pc, inst},
          {vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].pc, vecs[i].inst});
    end
    nxt();
    redirect = 1'b0;
    chk("table_consumed", sb_consumed, 6);

    // Back-pressure until full, then drain with no loss or duplication.
    do_reset();
    run(20);
    tick();
    chk("full_hold", {imem_req, imem_addr, inst_valid, inst_pc, inst},
        {1'b0, 8'h04, 1'b1, 8'h00, 5'h00});
    nxt();
    push_seq(8'h00, 10);
    inst_ready = 1'b1;
    wait_consumed("full_drain", 10, 80);
    inst_ready = 1'b0;

    // Reset while in FETCH with 3 entries buffered.
    do_reset();
    run(6);
    tick();
    chk("pre_reset3", {imem_req, imem_addr, inst_valid, inst_pc}, {1'b1, 8'h03, 1'b1, 8'h00});
    nxt();
    reset = 1'b1;
    tick();
    nxt();
    tick();
    chk("mid_reset", {imem_req, inst_valid, inst_pc, inst}, {1'b0, 1'b0, 8'h00, 5'h00});
    nxt();
    reset = 1'b0;
    tick();
    chk("post_reset_req", {imem_req, imem_addr, inst_valid}, {1'b1, 8'h00, 1'b0});
    nxt();
    push_seq(8'h00, 4);
    inst_ready = 1'b1;
    wait_consumed("post_reset_stream", 4, 40);
    inst_ready = 1'b0;

    // Slow memory, redirect to 0x40 in the second wait cycle.
    mem_delay = 3;
    do_reset();
    inst_ready = 1'b1;
    tick();
    chk("slow_c0", {imem_req, imem_addr}, {1'b1, 8'h00});
    nxt();
    tick();
    chk("slow_c1", {imem_req, imem_addr, inst_valid}, {1'b1, 8'h00, 1'b0});
    nxt();
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    chk("slow_redir", {imem_req, imem_addr}, {1'b1, 8'h00});
    nxt();
    redirect = 1'b0;
    tick();
    chk("drop_hold", {imem_req, imem_addr, inst_valid}, {1'b1, 8'h00, 1'b0});
    nxt();
    tick();
    chk("drop_ack", {imem_req, imem_addr}, {1'b1, 8'h00});
    nxt();
    mem_delay = 0;
    tick();
    chk("after_drop", {imem_req, imem_addr, inst_valid}, {1'b1, 8'h40, 1'b0});
    nxt();
    push_seq(8'h40, 4);
    wait_consumed("redir_stream", 4, 40);
    inst_ready = 1'b0;

    // Redirect to 0x10 together with ack and pop, 2 entries buffered.
    mem_delay = 0;
    do_reset();
    push_seq(8'h00, 1);
    push_seq(8'h10, 3);
    run(5);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    chk("flush_cycle", {imem_req, imem_addr, inst_valid, inst_pc}, {1'b1, 8'h02, 1'b1, 8'h00});
    nxt();
    redirect = 1'b0;
    tick();
    chk("after_flush", {imem_req, imem_addr, inst_valid, inst_pc, inst},
        {1'b1, 8'h10, 1'b0, 8'h00, 5'h00});
    nxt();
    wait_consumed("flush_stream", 4, 40);
    inst_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
